// File: rtl/st7789_spi_rx.sv
// Display-side model of an ST7789 panel on the 9-bit (DC + 8-bit) SPI stream:
// deserialises bytes, decodes the command subset and emits RAMWR pixel write strobes.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | waiting for a command byte
// S_COLMOD | next data byte loads colmod
// S_MADCTL | next data byte loads madctl
// S_CASET  | collecting XS_hi, XS_lo, XE_hi, XE_lo
// S_RASET  | collecting YS_hi, YS_lo, YE_hi, YE_lo
// S_RAMWR  | pairing data bytes into RGB565 pixel writes
module st7789_spi_rx #(
    parameter int         IDLE_CYC = 64,
    parameter logic [7:0] XE_RST   = 8'd239,
    parameter logic [7:0] YE_RST   = 8'd239
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        st7789_SCL,
    input  logic        st7789_SDA,
    input  logic        st7789_DC,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_dc,
    output logic        px_we,
    output logic [15:0] px_addr,
    output logic [15:0] px_data,
    output logic        disp_on,
    output logic        sleep_out,
    output logic [7:0]  colmod,
    output logic [7:0]  madctl,
    output logic        frame_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COLMOD = 3'd1;
    localparam logic [2:0] S_MADCTL = 3'd2;
    localparam logic [2:0] S_CASET  = 3'd3;
    localparam logic [2:0] S_RASET  = 3'd4;
    localparam logic [2:0] S_RAMWR  = 3'd5;

    localparam int            TW        = $clog2(IDLE_CYC + 1);
    localparam logic [TW-1:0] IDLE_LOAD = TW'(IDLE_CYC - 1);

    logic          scl_m, scl_s, scl_d;
    logic          sda_m, sda_s;
    logic          dc_m, dc_s;
    logic          scl_rise;
    logic [6:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;

    logic [2:0]    state;
    logic [1:0]    pidx;
    logic          half;
    logic [7:0]    hi_byte;
    logic [7:0]    x, y, xs, xe, ys, ye;

    // SCL sync flops reset to the idle-high level so release from reset never fakes an edge
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_d <= 1'b1;
            sda_m <= 1'b0;
            sda_s <= 1'b0;
            dc_m  <= 1'b0;
            dc_s  <= 1'b0;
        end else begin
            scl_m <= st7789_SCL;
            scl_s <= scl_m;
            scl_d <= scl_s;
            sda_m <= st7789_SDA;
            sda_s <= sda_m;
            dc_m  <= st7789_DC;
            dc_s  <= dc_m;
        end
    end

    assign scl_rise = scl_s & ~scl_d;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rx_dc    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (scl_rise) begin
                shreg    <= {shreg[5:0], sda_s};
                bit_cnt  <= bit_cnt + 3'd1;
                idle_cnt <= IDLE_LOAD;
                if (bit_cnt == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_byte  <= {shreg, sda_s};
                    rx_dc    <= dc_s;
                end
            end else if (bit_cnt != 3'd0) begin
                // terminal count drops the partial byte
                if (idle_cnt == '0)
                    bit_cnt <= 3'd0;
                else
                    idle_cnt <= idle_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state      <= S_IDLE;
            pidx       <= '0;
            half       <= 1'b0;
            hi_byte    <= '0;
            x          <= '0;
            y          <= '0;
            xs         <= '0;
            xe         <= XE_RST;
            ys         <= '0;
            ye         <= YE_RST;
            px_we      <= 1'b0;
            px_addr    <= '0;
            px_data    <= '0;
            disp_on    <= 1'b0;
            sleep_out  <= 1'b0;
            colmod     <= '0;
            madctl     <= '0;
            frame_done <= 1'b0;
        end else begin
            px_we      <= 1'b0;
            frame_done <= 1'b0;
            if (rx_valid) begin
                if (!rx_dc) begin
                    state <= S_IDLE;
                    half  <= 1'b0;
                    pidx  <= '0;
                    case (rx_byte)
                        8'h01: begin
                            disp_on   <= 1'b0;
                            sleep_out <= 1'b0;
                            colmod    <= '0;
                            madctl    <= '0;
                            px_addr   <= '0;
                            px_data   <= '0;
                            xs        <= '0;
                            xe        <= XE_RST;
                            ys        <= '0;
                            ye        <= YE_RST;
                        end
                        8'h11: sleep_out <= 1'b1;
                        8'h29: disp_on <= 1'b1;
                        8'h3A: state <= S_COLMOD;
                        8'h36: state <= S_MADCTL;
                        8'h2A: state <= S_CASET;
                        8'h2B: state <= S_RASET;
                        8'h2C: begin
                            state <= S_RAMWR;
                            x     <= xs;
                            y     <= ys;
                        end
                        default: ;
                    endcase
                end else begin
                    case (state)
                        S_COLMOD: begin
                            colmod <= rx_byte;
                            state  <= S_IDLE;
                        end
                        S_MADCTL: begin
                            madctl <= rx_byte;
                            state  <= S_IDLE;
                        end
                        S_CASET, S_RASET: begin
                            // only the low bytes matter: coordinates are 8-bit
                            if (pidx == 2'd1) begin
                                if (state == S_CASET) xs <= rx_byte;
                                else                  ys <= rx_byte;
                            end else if (pidx == 2'd3) begin
                                if (state == S_CASET) xe <= rx_byte;
                                else                  ye <= rx_byte;
                            end
                            pidx <= pidx + 2'd1;
                            if (pidx == 2'd3) state <= S_IDLE;
                        end
                        S_RAMWR: begin
                            if (!half) begin
                                hi_byte <= rx_byte;
                                half    <= 1'b1;
                            end else begin
                                half       <= 1'b0;
                                px_we      <= 1'b1;
                                px_addr    <= {y, x};
                                px_data    <= {hi_byte, rx_byte};
                                frame_done <= (x == xe) && (y == ye);
                                if (x == xe) begin
                                    x <= xs;
                                    y <= (y == ye) ? ys : y + 8'd1;
                                end else begin
                                    x <= x + 8'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_st7789_spi_rx.sv
// Bench for st7789_spi_rx: drives the SPI pins at the fastest SCL rate and scoreboards
// every received byte and pixel write against expectations queued by the stimulus.
module tb_st7789_spi_rx;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda = 1'b0;
    logic        dc = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_dc;
    logic        px_we;
    logic [15:0] px_addr;
    logic [15:0] px_data;
    logic        disp_on;
    logic        sleep_out;
    logic [7:0]  colmod;
    logic [7:0]  madctl;
    logic        frame_done;

    st7789_spi_rx dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .st7789_SCL (scl),
        .st7789_SDA (sda),
        .st7789_DC  (dc),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_dc      (rx_dc),
        .px_we      (px_we),
        .px_addr    (px_addr),
        .px_data    (px_data),
        .disp_on    (disp_on),
        .sleep_out  (sleep_out),
        .colmod     (colmod),
        .madctl     (madctl),
        .frame_done (frame_done)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic       dc;
        logic [7:0] b;
        int         t;
    } rx_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        fd;
        int          t;
    } px_exp_t;

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic       s;
        logic       d;
        logic [7:0] cm;
        logic [7:0] md;
    } cfg_vec_t;

    rx_exp_t rx_q[$];
    px_exp_t px_q[$];
    int      cyc = 0;
    int      last_t = 0;
    int      checks = 0;
    int      failures = 0;
    int      fd_count = 0;

    always @(posedge w_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge w_clk) begin : monitor
        rx_exp_t re;
        px_exp_t pe;
        if (w_rst_n) begin
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected: got byte %0h dc %0b expected no byte", rx_byte, rx_dc);
                end else begin
                    re = rx_q.pop_front();
                    check("rx_byte", 64'(rx_byte), 64'(re.b));
                    check("rx_dc", 64'(rx_dc), 64'(re.dc));
                    check("rx_latency", 64'(cyc - re.t), 64'd3);
                end
            end
            if (px_we) begin
                if (px_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL px_unexpected: got addr %0h data %0h expected no write", px_addr, px_data);
                end else begin
                    pe = px_q.pop_front();
                    check("px_addr", 64'(px_addr), 64'(pe.addr));
                    check("px_data", 64'(px_data), 64'(pe.data));
                    check("frame_done", 64'(frame_done), 64'(pe.fd));
                    check("px_latency", 64'(cyc - pe.t), 64'd4);
                end
            end
            if (frame_done && !px_we) begin
                checks++;
                failures++;
                $display("FAIL frame_done_alone: got frame_done 1 with px_we 0, expected 0");
            end
            if (frame_done) fd_count++;
        end
    end

    task automatic send_bits(input logic d, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge w_clk);
            scl = 1'b0;
            sda = b[7-i];
            if (i == 0) dc = d;
            @(negedge w_clk);
            scl = 1'b1;
            last_t = cyc;
        end
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        send_bits(d, b, 8);
        rx_q.push_back('{dc: d, b: b, t: last_t});
    endtask

    task automatic send_px(input logic [15:0] data, input logic [15:0] addr, input logic fd);
        send_byte(1'b1, data[15:8]);
        send_byte(1'b1, data[7:0]);
        px_q.push_back('{addr: addr, data: data, fd: fd, t: last_t});
    endtask

    task automatic set_window(input logic [7:0] xs, input logic [7:0] xe,
                              input logic [7:0] ys, input logic [7:0] ye);
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, xs);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, xe);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, ys);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, ye);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge w_clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (rx_q.size() != 0 || px_q.size() != 0); i++)
            @(negedge w_clk);
        check({name, "_rx_pending"}, 64'(rx_q.size()), 64'd0);
        check({name, "_px_pending"}, 64'(px_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({rx_valid, rx_byte, rx_dc, px_we, px_addr, px_data,
                    disp_on, sleep_out, colmod, madctl, frame_done});
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        cfg_vec_t    tv[10];
        logic [15:0] small_addr[6];
        logic [15:0] wrap_addr[5];
        int          fd0;

        tv[0] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 8'h00};
        tv[1] = '{1'b0, 8'h3A, 1'b1, 1'b0, 8'h00, 8'h00};
        tv[2] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h55, 8'h00};
        tv[3] = '{1'b0, 8'h36, 1'b1, 1'b0, 8'h55, 8'h00};
        tv[4] = '{1'b1, 8'h60, 1'b1, 1'b0, 8'h55, 8'h60};
        tv[5] = '{1'b1, 8'h77, 1'b1, 1'b0, 8'h55, 8'h60};
        tv[6] = '{1'b0, 8'h36, 1'b1, 1'b0, 8'h55, 8'h60};
        tv[7] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h55, 8'h00};
        tv[8] = '{1'b0, 8'h29, 1'b1, 1'b1, 8'h55, 8'h00};
        tv[9] = '{1'b0, 8'hC5, 1'b1, 1'b1, 8'h55, 8'h00};

        small_addr[0] = 16'h050A; small_addr[1] = 16'h050B; small_addr[2] = 16'h060A;
        small_addr[3] = 16'h060B; small_addr[4] = 16'h050A; small_addr[5] = 16'h050B;
        wrap_addr[0] = 16'h10FE; wrap_addr[1] = 16'h10FF; wrap_addr[2] = 16'h1000;
        wrap_addr[3] = 16'h1001; wrap_addr[4] = 16'h10FE;

        wait_cyc(3);
        check("reset_outputs", all_outputs(), 64'd0);
        w_rst_n = 1'b1;
        wait_cyc(4);

        // configuration commands
        for (int i = 0; i < 10; i++) begin
            send_byte(tv[i].dc, tv[i].b);
            wait_cyc(5);
            check($sformatf("cfg_%0d", i), 64'({sleep_out, disp_on, colmod, madctl}),
                  64'({tv[i].s, tv[i].d, tv[i].cm, tv[i].md}));
        end
        drain("cfg");

        // two full-width rows ending at the (XE,YE) corner
        set_window(8'h00, 8'hEF, 8'hEE, 8'hEF);
        send_byte(1'b0, 8'h2C);
        fd0 = fd_count;
        for (int yy = 8'hEE; yy <= 8'hEF; yy++)
            for (int xx = 0; xx <= 8'hEF; xx++)
                send_px(16'hF800, {8'(yy), 8'(xx)}, (yy == 8'hEF) && (xx == 8'hEF));
        drain("rows");
        check("rows_frame_count", 64'(fd_count - fd0), 64'd1);

        // 2x2 window, wrapping into a second frame
        set_window(8'h0A, 8'h0B, 8'h05, 8'h06);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 6; i++)
            send_px(16'hA000 + 16'(i), small_addr[i], i == 3);
        drain("small");

        // XS > XE: column counter runs through 255
        set_window(8'hFE, 8'h01, 8'h10, 8'h10);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++)
            send_px(16'h5A00 + 16'(i), wrap_addr[i], i == 3);
        drain("xwrap");

        // SWRESET, then unpaired high byte aborted by a command
        send_byte(1'b0, 8'h01);
        wait_cyc(5);
        check("swreset_cfg", 64'({sleep_out, disp_on, colmod, madctl}), 64'd0);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAB);
        send_byte(1'b0, 8'h29);
        wait_cyc(5);
        check("abort_disp_on", 64'(disp_on), 64'd1);
        send_byte(1'b0, 8'h2C);
        send_px(16'h1234, 16'h0000, 1'b0);
        drain("abort");

        // fragment discarded by idle timeout; next byte is a clean CASET
        send_bits(1'b1, 8'b1011_0000, 5);
        wait_cyc(64);
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h0A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h0B);
        drain("frag");

        // async reset in the middle of a pixel's low byte
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hCD);
        drain("pre_reset");
        check("pre_reset_disp_on", 64'(disp_on), 64'd1);
        send_bits(1'b1, 8'hEF, 2);
        @(negedge w_clk);
        scl = 1'b0;
        sda = 1'b1;
        #2;
        w_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        rx_q.delete();
        px_q.delete();
        scl = 1'b1;
        wait_cyc(3);
        w_rst_n = 1'b1;
        wait_cyc(10);
        check("post_reset_outputs", all_outputs(), 64'd0);
        send_byte(1'b0, 8'h2C);
        send_px(16'h0F0F, 16'h0000, 1'b0);
        send_px(16'h0F10, 16'h0001, 1'b0);
        send_px(16'h0F11, 16'h0002, 1'b0);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/st7789_spi_rx.md
Name: st7789_spi_rx

Overview:
- Display-side responder for the 9-bit (DC + 8-bit) ST7789 SPI stream that the design drives out on st7789_SCL/SDA/DC. It deserialises bytes and decodes the ST7789 command subset the design uses: SWRESET, SLPOUT, COLMOD, MADCTL, CASET, RASET, RAMWR, DISPON.
- RAMWR pixel data is turned into write strobes for a 256x256x16 video memory, giving a bit-accurate panel model for simulation and for on-FPGA loopback checking of the display path.

Parameters:
- IDLE_CYC, 64: clocks with no SCL rising edge after which a partial byte is discarded.
- XE_RST, 239: CASET end column after reset/SWRESET.
- YE_RST, 239: RASET end row after reset/SWRESET.

Ports:
- w_clk  in  1  system clock (100MHz)
- w_rst_n  in  1  reset, asynchronous, active-low
- st7789_SCL  in  1  SPI clock, idle high
- st7789_SDA  in  1  SPI data, MSB first
- st7789_DC  in  1  0 = command, 1 = data/parameter
- rx_valid  out  1  one-cycle strobe: a byte was received
- rx_byte  out  8  received byte, valid with rx_valid
- rx_dc  out  1  DC of the received byte
- px_we  out  1  one-cycle pixel write strobe
- px_addr  out  16  {y[7:0], x[7:0]}
- px_data  out  16  RGB565 pixel, high byte first on the wire
- disp_on  out  1  set by DISPON (0x29)
- sleep_out  out  1  set by SLPOUT (0x11)
- colmod  out  8  last COLMOD parameter
- madctl  out  8  last MADCTL parameter
- frame_done  out  1  one-cycle pulse when the pixel at (XE,YE) is written

Behaviour:
- Reset (w_rst_n=0, async): all outputs 0. XS=0, XE=XE_RST, YS=0, YE=YE_RST. Bit counter 0, FSM in IDLE.
- Input sampling:
  - SCL, SDA and DC each pass through a 2-FF synchroniser with identical delay.
  - Rising edge = SCL_s & ~SCL_d. SCL toggles at most once per w_clk, so edges must be detected at 2-cycle SCL period.
  - On each rising edge, shift SDA_s in as the LSB and increment the 3-bit bit counter.
  - DC is sampled on the 8th edge.
- Byte output: the cycle after the 8th edge, rx_valid=1 with rx_byte and rx_dc. Bit counter returns to 0; back-to-back bytes are supported with no gap.
- Idle timeout: if IDLE_CYC cycles pass without a rising edge while the bit counter is nonzero, clear the bit counter. The partial byte is dropped and no rx_valid is produced.
- Decoder FSM, advanced on rx_valid:
  - IDLE: DC=1 bytes are ignored. DC=0 bytes are decoded:
    - 0x01: SWRESET; restore all reset values.
    - 0x11: sleep_out=1.
    - 0x29: disp_on=1.
    - 0x3A: go to P_COLMOD.
    - 0x36: go to P_MADCTL.
    - 0x2A: go to P_CASET with parameter index 0.
    - 0x2B: go to P_RASET with parameter index 0.
    - 0x2C: go to RAMWR; set x=XS, y=YS, half=0.
    - Any other command: no effect; stay in or return to IDLE.
  - Any DC=0 byte, in any state, aborts the current state and is decoded as above. An unpaired RAMWR high byte is discarded.
  - P_COLMOD / P_MADCTL: the first DC=1 byte loads the register; return to IDLE.
  - P_CASET: 4 DC=1 bytes, in order XS_hi, XS_lo, XE_hi, XE_lo.
    - Only the lo bytes are stored (8-bit coordinates); hi bytes are ignored.
    - After the 4th byte, return to IDLE.
    - Values take effect immediately for the next RAMWR.
  - P_RASET: same as P_CASET, for YS/YE.
  - RAMWR:
    - DC=1 byte with half=0: latch it as px_data[15:8]; set half=1.
    - DC=1 byte with half=1: the cycle after rx_valid, px_we=1, px_addr={y,x}, px_data={hi, byte}; set half=0.
    - After each pixel: if x==XE then x=XS, else x=x+1 (8-bit wrap). On the x wrap: if y==YE then y=YS, else y=y+1.
    - If XS>XE the column counter runs modulo 256 through 255 to XE.
    - Writing the pixel at x==XE and y==YE raises frame_done in the same cycle as px_we. The pointer wraps to (XS,YS) and further data continues into a new frame.
- Latency: pin SCL rising edge of the last bit → rx_valid is 3 cycles; → px_we is 4 cycles.
- Reset asserted mid-byte or mid-frame: immediate return to reset values. Nothing is written after deassertion until a new RAMWR.

Test Plan:
- Send 0x11, 0x3A, 0x55, 0x36, 0x00, 0x29 → rx_valid 6 times; sleep_out=1, colmod=0x55, madctl=0x00, disp_on=1, px_we never asserted.
- CASET 00 00 00 EF, RASET 00 00 00 EF, RAMWR, then 115200 data bytes of F8 00 → 57600 px_we with px_data=0xF800. Addresses run 0x0000…0x00EF, 0x0100…, ending 0xEFEF; exactly one frame_done, on the last pixel.
- CASET 00 0A 00 0B, RASET 00 05 00 06, RAMWR, pixels P0..P5 → addresses 0x050A, 0x050B, 0x060A, 0x060B, then 0x050A, 0x050B. frame_done on the 4th pixel only.
- RAMWR, data AB, then command 0x29 → no px_we; disp_on=1. A following RAMWR with 12 34 writes 0x1234 at (XS,YS).
- Clock 5 bits, then hold SCL high 64 cycles, then send 0x2A → the first rx_valid carries 0x2A, rx_dc=0; no rx_valid for the fragment.
- Assert w_rst_n low during the 3rd bit of a RAMWR data byte → all outputs 0 asynchronously. After release, CASET range is back to 0..XE_RST.
